// File: rtl/asic_pipebuf_pkg.sv
// Shared state encoding and constants for the asic_pipebuf elastic buffer.
// Optional build macro used by the stage: ASIC_PIPEBUF_HOLD_EN.
package asic_pipebuf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } pipebuf_state_t;

    localparam int PIPEBUF_CAP_PER_STAGE = 2;

endpackage

// File: rtl/asic_pipebuf_stage.sv
// One 2-entry skid stage: in_ready comes straight from the state register, so no ready path crosses stages.
// ASIC_PIPEBUF_HOLD_EN: data registers load only on a real transfer, otherwise main follows in_data when free.
module asic_pipebuf_stage
    import asic_pipebuf_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    pipebuf_state_t state_q, state_d;
    logic [DW-1:0]  main_q, main_d;
    logic [DW-1:0]  skid_q, skid_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_valid) state_d = BUSY;
`ifdef ASIC_PIPEBUF_HOLD_EN
                if (in_valid) main_d = in_data;
`else
                main_d = in_data;
`endif
            end
            BUSY: begin
                if (in_valid && !out_ready)      state_d = FULL;
                else if (!in_valid && out_ready) state_d = EMPTY;
`ifdef ASIC_PIPEBUF_HOLD_EN
                if (in_valid && out_ready)  main_d = in_data;
                if (in_valid && !out_ready) skid_d = in_data;
`else
                // Loading without in_valid is harmless: the stage only keeps them on a real push.
                if (out_ready) main_d = in_data;
                else           skid_d = in_data;
`endif
            end
            FULL: begin
                if (out_ready) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Payload registers carry no reset.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/asic_pipebuf.sv
// Elastic valid/ready pipeline buffer of DEPTH skid stages; DEPTH=0 degenerates to wires.
// Build option ASIC_PIPEBUF_HOLD_EN is consumed inside asic_pipebuf_stage.
module asic_pipebuf
    import asic_pipebuf_pkg::*;
#(
    parameter int DW    = 1,
    parameter int DEPTH = 2,
    parameter     PROP  = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    // PROP only steers tech mapping and the per-stage capacity is informational.
    logic [7:0] unused_cfg;
    assign unused_cfg = 8'(PROP) ^ 8'(PIPEBUF_CAP_PER_STAGE);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk;
        assign unused_clk = clk ^ reset;
        assign in_ready   = out_ready;
        assign out_valid  = in_valid;
        assign out_data   = in_data;
    end else begin : g_pipe
        logic          vld [DEPTH+1];
        logic          rdy [DEPTH+1];
        logic [DW-1:0] dat [DEPTH+1];

        assign vld[0]     = in_valid;
        assign dat[0]     = in_data;
        assign in_ready   = rdy[0];
        assign rdy[DEPTH] = out_ready;
        assign out_valid  = vld[DEPTH];
        assign out_data   = dat[DEPTH];

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            asic_pipebuf_stage #(.DW(DW)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (vld[k]),
                .in_ready  (rdy[k]),
                .in_data   (dat[k]),
                .out_valid (vld[k+1]),
                .out_ready (rdy[k+1]),
                .out_data  (dat[k+1])
            );
        end
    end

endmodule

// File: tb/tb_asic_pipebuf.sv
// Directed and random bench for asic_pipebuf, DW=8 at DEPTH 0..4, scoreboard per instance.
// The hold-data step is compiled in when ASIC_PIPEBUF_HOLD_EN is defined.
module tb_asic_pipebuf;

    localparam int NI = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       iv   [NI];
    logic       ir   [NI];
    logic       ov   [NI];
    logic       ordy [NI];
    logic [7:0] id   [NI];
    logic [7:0] od   [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        asic_pipebuf #(.DW(8), .DEPTH(k), .PROP("DEFAULT")) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (iv[k]),
            .in_ready  (ir[k]),
            .in_data   (id[k]),
            .out_valid (ov[k]),
            .out_ready (ordy[k]),
            .out_data  (od[k])
        );
    end

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] sbq [NI][$];
    logic       took       [NI];
    logic       stall_prev [NI];
    logic [7:0] stall_data [NI];
    logic [7:0] nextval    [NI];
    int         first_in   [NI];
    int         first_out  [NI];
    int         last_out   [NI];
    int         n_acc      [NI];
    int         n_dlv      [NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NI; k++) begin
            sbq[k].delete();
            took[k]       = 1'b0;
            stall_prev[k] = 1'b0;
            stall_data[k] = 8'h00;
            first_in[k]   = -1;
            first_out[k]  = -1;
            last_out[k]   = -1;
            n_acc[k]      = 0;
            n_dlv[k]      = 0;
        end
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < NI; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
            id[k]   = 8'h00;
        end
    endtask

    // Source obeys the protocol: a presented word stays until it is taken.
    task automatic src(input int k, input logic want);
        if (!iv[k] || took[k]) begin
            iv[k] = want;
            if (want) begin
                id[k]      = nextval[k];
                nextval[k] = nextval[k] + 8'd1;
            end
        end
    endtask

    task automatic observe();
        for (int k = 0; k < NI; k++) begin
            if (stall_prev[k]) begin
                chk($sformatf("stall_valid_d%0d", k), 32'(ov[k]), 32'd1);
                chk($sformatf("stall_data_d%0d", k), 32'(od[k]), 32'(stall_data[k]));
            end
            took[k] = iv[k] && ir[k];
            if (took[k]) begin
                sbq[k].push_back(id[k]);
                n_acc[k]++;
                if (first_in[k] < 0) first_in[k] = cyc;
            end
            if (ov[k] && ordy[k]) begin
                n_dlv[k]++;
                if (first_out[k] < 0) first_out[k] = cyc;
                last_out[k] = cyc;
                chk($sformatf("sb_nonempty_d%0d", k), 32'(sbq[k].size() != 0), 32'd1);
                if (sbq[k].size() != 0)
                    chk($sformatf("order_d%0d", k), 32'(od[k]), 32'(sbq[k].pop_front()));
            end
            stall_prev[k] = ov[k] && !ordy[k];
            stall_data[k] = od[k];
        end
    endtask

    task automatic cycle();
        #1;
        observe();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        clear_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset and idle
        reset = 1'b1;
        idle_inputs();
        clear_model();
        #1;
        for (int k = 1; k < NI; k++) begin
            chk($sformatf("rst_valid_d%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("rst_ready_d%0d", k), 32'(ir[k]), 32'd1);
        end
        chk("rst_valid_d0", 32'(ov[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle();
        cycle();
        for (int k = 1; k < NI; k++) begin
            chk($sformatf("idle_valid_d%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("idle_ready_d%0d", k), 32'(ir[k]), 32'd1);
        end

        // DEPTH=3 back-to-back stream
        ordy[3]    = 1'b1;
        nextval[3] = 8'h01;
        for (int w = 0; w < 16; w++) begin
            src(3, 1'b1);
            cycle();
            chk("stream_ready", 32'(ir[3]), 32'd1);
        end
        for (int w = 0; w < 6; w++) begin
            src(3, 1'b0);
            cycle();
        end
        chk("stream_latency", 32'(first_out[3] - first_in[3]), 32'd3);
        chk("stream_rate", 32'(last_out[3] - first_out[3]), 32'd15);
        chk("stream_count", 32'(n_dlv[3]), 32'd16);
        chk("stream_drained", 32'(sbq[3].size()), 32'd0);

        // DEPTH=2 fill to capacity, then drain
        do_reset();
        nextval[2] = 8'h20;
        for (int w = 0; w < 8; w++) begin
            src(2, 1'b1);
            cycle();
        end
        chk("fill_accepted", 32'(n_acc[2]), 32'd4);
        for (int w = 0; w < 3; w++) begin
            src(2, 1'b1);
            cycle();
            chk("fill_ready_low", 32'(ir[2]), 32'd0);
            chk("fill_valid", 32'(ov[2]), 32'd1);
        end
        ordy[2] = 1'b1;
        for (int w = 0; w < 10; w++) begin
            src(2, 1'b0);
            cycle();
        end
        chk("drain_count", 32'(n_dlv[2]), 32'd5);
        chk("drain_ready", 32'(ir[2]), 32'd1);
        chk("drain_valid", 32'(ov[2]), 32'd0);
        chk("drain_empty", 32'(sbq[2].size()), 32'd0);

        // Random traffic on every depth
        do_reset();
        for (int k = 0; k < NI; k++) nextval[k] = 8'(k * 40);
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NI; k++) begin
                src(k, 1'($urandom_range(1, 0)));
                ordy[k] = 1'($urandom_range(1, 0));
            end
            cycle();
        end
        for (int k = 0; k < NI; k++) ordy[k] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < NI; k++) src(k, 1'b0);
            cycle();
        end
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rand_empty_d%0d", k), 32'(sbq[k].size()), 32'd0);
            chk($sformatf("rand_balance_d%0d", k), 32'(n_dlv[k]), 32'(n_acc[k]));
        end

        // Reset with words in flight (DEPTH=2)
        do_reset();
        nextval[2] = 8'h60;
        for (int w = 0; w < 3; w++) begin
            src(2, 1'b1);
            cycle();
        end
        src(2, 1'b0);
        cycle();
        chk("flight_valid", 32'(ov[2]), 32'd1);
        reset = 1'b1;
        #1;
        chk("flight_rst_valid", 32'(ov[2]), 32'd0);
        chk("flight_rst_ready", 32'(ir[2]), 32'd1);
        clear_model();
        @(negedge clk);
        reset   = 1'b0;
        ordy[2] = 1'b1;
        for (int w = 0; w < 6; w++) cycle();
        chk("flight_no_old", 32'(n_dlv[2]), 32'd0);

        // DEPTH=0 pass-through
        iv[0] = 1'b1;
        id[0] = 8'h3C;
        ordy[0] = 1'b0;
        #1;
        chk("pass_valid", 32'(ov[0]), 32'd1);
        chk("pass_data", 32'(od[0]), 32'h3C);
        chk("pass_ready_lo", 32'(ir[0]), 32'd0);
        ordy[0] = 1'b1;
        #1;
        chk("pass_ready_hi", 32'(ir[0]), 32'd1);
        iv[0] = 1'b0;
        @(negedge clk);

`ifdef ASIC_PIPEBUF_HOLD_EN
        // Delivered word stays on out_data while idle
        do_reset();
        ordy[2] = 1'b1;
        iv[2]   = 1'b1;
        id[2]   = 8'hA5;
        cycle();
        iv[2] = 1'b0;
        id[2] = 8'h5A;
        for (int w = 0; w < 4; w++) cycle();
        chk("hold_delivered", 32'(n_dlv[2]), 32'd1);
        for (int w = 0; w < 4; w++) begin
            cycle();
            chk("hold_valid", 32'(ov[2]), 32'd0);
            chk("hold_data", 32'(od[2]), 32'hA5);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
